// File: rtl/alu_issue_stage_pkg.sv
// Shared definitions for the ALU issue/writeback stage: datapath width,
// opcode encoding and small opcode helpers.
package alu_issue_stage_pkg;

  // Width the downstream ALU is built for.
  localparam int ALU_DW = 16;

  // Opcode field width.
  localparam int OP_W = 3;

  // Operator encoding understood by the ALU.
  typedef enum logic [OP_W-1:0] {
    OP_NEG     = 3'd0,  // -A
    OP_INC     = 3'd1,  // A + 1
    OP_ADD     = 3'd2,  // A + B + C
    OP_ASR_ADD = 3'd3,  // A + (B >>> 1)
    OP_AND     = 3'd4,  // A & B
    OP_OR      = 3'd5,  // A | B
    OP_CAT     = 3'd6,  // {A[7:0], B[7:0]}
    OP_LOADI   = 3'd7   // immediate load, ALU output ignored
  } alu_op_e;

  // Only the three-operand add consumes the carry input.
  function automatic logic op_uses_carry(alu_op_e op);
    return (op == OP_ADD);
  endfunction

  // Immediate loads take their result from the instruction, not the ALU.
  function automatic logic op_bypasses_alu(alu_op_e op);
    return (op == OP_LOADI);
  endfunction

endpackage

// File: rtl/alu_issue_stage_if.sv
// Bundle of the issue handshake, the ALU operand/result bus and the
// result handshake. "slave" is the issue stage's view, "master" the
// surrounding datapath (instruction source, ALU, result consumer).
interface alu_issue_stage_if #(
  parameter int NREGS = 4,
  parameter int DW    = 16
);
  localparam int RW = (NREGS > 1) ? $clog2(NREGS) : 1;

  // Instruction input
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    in_op;
  logic [RW-1:0] in_rd;
  logic [RW-1:0] in_rs1;
  logic [RW-1:0] in_rs2;
  logic          in_cin;
  logic [DW-1:0] in_imm;

  // ALU operand and result bus
  logic [DW-1:0] alu_A;
  logic [DW-1:0] alu_B;
  logic          alu_C;
  logic [2:0]    alu_op;
  logic [DW-1:0] alu_W;
  logic          alu_zero;
  logic          alu_neg;

  // Result output
  logic          res_valid;
  logic          res_ready;
  logic [DW-1:0] res_data;
  logic [RW-1:0] res_rd;
  logic          res_zero;
  logic          res_neg;

  modport slave (
    input  in_valid, in_op, in_rd, in_rs1, in_rs2, in_cin, in_imm,
    input  alu_W, alu_zero, alu_neg,
    input  res_ready,
    output in_ready,
    output alu_A, alu_B, alu_C, alu_op,
    output res_valid, res_data, res_rd, res_zero, res_neg
  );

  modport master (
    output in_valid, in_op, in_rd, in_rs1, in_rs2, in_cin, in_imm,
    output alu_W, alu_zero, alu_neg,
    output res_ready,
    input  in_ready,
    input  alu_A, alu_B, alu_C, alu_op,
    input  res_valid, res_data, res_rd, res_zero, res_neg
  );

endinterface

// File: rtl/alu_issue_stage_regfile.sv
// Small register file: NREGS x DW flops, two asynchronous read ports,
// one synchronous write port, synchronous clear. A read of the entry
// being written in the same cycle returns the write data, which gives
// the issue stage its EX->operand forwarding for free.
module alu_issue_stage_regfile #(
  parameter int NREGS = 4,
  parameter int DW    = 16,
  parameter int RW    = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [RW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [RW-1:0] raddr1,
  output logic [DW-1:0] rdata1,
  input  logic [RW-1:0] raddr2,
  output logic [DW-1:0] rdata2
);

  logic [DW-1:0] mem [NREGS];

  generate
    for (genvar gi = 0; gi < NREGS; gi++) begin : g_entry
      logic [DW-1:0] entry_q;
      logic [DW-1:0] entry_d;

      // Entry takes the write data only when addressed by the write port.
      always_comb begin
        entry_d = entry_q;
        if (we && (waddr == RW'(gi))) begin
          entry_d = wdata;
        end
      end

      // Entry storage; reset wins over a coincident write.
      always_ff @(posedge clk) begin
        if (rst) begin
          entry_q <= '0;
        end else begin
          entry_q <= entry_d;
        end
      end

      assign mem[gi] = entry_q;
    end
  endgenerate

  // Read ports with write-through so a same-cycle writer is visible.
  always_comb begin
    rdata1 = mem[raddr1];
    rdata2 = mem[raddr2];
    if (we && (waddr == raddr1)) begin
      rdata1 = wdata;
    end
    if (we && (waddr == raddr2)) begin
      rdata2 = wdata;
    end
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Issue/writeback stage in front of an external combinational ALU.
// EX register drives the ALU operands; the EX result (ALU output, or the
// immediate for LOADI) is written back and captured into the RES register
// on the same edge. The only stall is a held result (res_ready low).
module alu_issue_stage
  import alu_issue_stage_pkg::*;
#(
  parameter int NREGS = 4,
  parameter int DW    = ALU_DW
) (
  input  logic clk,
  input  logic rst,
  alu_issue_stage_if.slave bus
);

  localparam int RW = (NREGS > 1) ? $clog2(NREGS) : 1;

  // Pipeline control
  logic ex_adv;
  logic in_ready;
  logic accept;

  // EX stage registers
  logic          ex_valid_q, ex_valid_d;
  logic [DW-1:0] ex_a_q,     ex_a_d;
  logic [DW-1:0] ex_b_q,     ex_b_d;
  logic          ex_c_q,     ex_c_d;
  alu_op_e       ex_op_q,    ex_op_d;
  logic [RW-1:0] ex_rd_q,    ex_rd_d;
  logic [DW-1:0] ex_imm_q,   ex_imm_d;

  // EX result as seen at the end of the EX cycle
  logic [DW-1:0] ex_res_data;
  logic          ex_res_zero;
  logic          ex_res_neg;

  // RES stage registers
  logic          res_valid_q, res_valid_d;
  logic [DW-1:0] res_data_q,  res_data_d;
  logic [RW-1:0] res_rd_q,    res_rd_d;
  logic          res_zero_q,  res_zero_d;
  logic          res_neg_q,   res_neg_d;

  // Register file read data (already forwarded from EX when needed)
  logic [DW-1:0] rs1_data;
  logic [DW-1:0] rs2_data;

  alu_issue_stage_regfile #(
    .NREGS (NREGS),
    .DW    (DW),
    .RW    (RW)
  ) u_regfile (
    .clk    (clk),
    .rst    (rst),
    .we     (ex_adv),
    .waddr  (ex_rd_q),
    .wdata  (ex_res_data),
    .raddr1 (bus.in_rs1),
    .rdata1 (rs1_data),
    .raddr2 (bus.in_rs2),
    .rdata2 (rs2_data)
  );

  // EX drains into RES when RES is empty or being consumed this cycle.
  always_comb begin
    ex_adv   = ex_valid_q & (~res_valid_q | bus.res_ready);
    in_ready = ~ex_valid_q | ex_adv;
    accept   = bus.in_valid & in_ready;
  end

  // EX result: immediate loads bypass the ALU, everything else uses it.
  always_comb begin
    if (op_bypasses_alu(ex_op_q)) begin
      ex_res_data = ex_imm_q;
      ex_res_zero = ~|ex_imm_q;
      ex_res_neg  = ex_imm_q[DW-1];
    end else begin
      ex_res_data = bus.alu_W;
      ex_res_zero = bus.alu_zero;
      ex_res_neg  = bus.alu_neg;
    end
  end

  // EX next state: load on accept, otherwise empty out after advancing.
  // Operand fields hold when not loading so the ALU inputs stay stable.
  always_comb begin
    ex_valid_d = ex_valid_q;
    ex_a_d     = ex_a_q;
    ex_b_d     = ex_b_q;
    ex_c_d     = ex_c_q;
    ex_op_d    = ex_op_q;
    ex_rd_d    = ex_rd_q;
    ex_imm_d   = ex_imm_q;
    if (accept) begin
      ex_valid_d = 1'b1;
      ex_a_d     = rs1_data;
      ex_b_d     = rs2_data;
      ex_op_d    = alu_op_e'(bus.in_op);
      ex_c_d     = op_uses_carry(alu_op_e'(bus.in_op)) ? bus.in_cin : 1'b0;
      ex_rd_d    = bus.in_rd;
      ex_imm_d   = bus.in_imm;
    end else if (ex_adv) begin
      ex_valid_d = 1'b0;
    end
  end

  // EX register bank.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_q <= 1'b0;
      ex_a_q     <= '0;
      ex_b_q     <= '0;
      ex_c_q     <= 1'b0;
      ex_op_q    <= OP_NEG;
      ex_rd_q    <= '0;
      ex_imm_q   <= '0;
    end else begin
      ex_valid_q <= ex_valid_d;
      ex_a_q     <= ex_a_d;
      ex_b_q     <= ex_b_d;
      ex_c_q     <= ex_c_d;
      ex_op_q    <= ex_op_d;
      ex_rd_q    <= ex_rd_d;
      ex_imm_q   <= ex_imm_d;
    end
  end

  // RES next state: capture on advance, drop valid once consumed.
  always_comb begin
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_rd_d    = res_rd_q;
    res_zero_d  = res_zero_q;
    res_neg_d   = res_neg_q;
    if (ex_adv) begin
      res_valid_d = 1'b1;
      res_data_d  = ex_res_data;
      res_rd_d    = ex_rd_q;
      res_zero_d  = ex_res_zero;
      res_neg_d   = ex_res_neg;
    end else if (res_valid_q && bus.res_ready) begin
      res_valid_d = 1'b0;
    end
  end

  // RES register bank.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_rd_q    <= '0;
      res_zero_q  <= 1'b0;
      res_neg_q   <= 1'b0;
    end else begin
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_rd_q    <= res_rd_d;
      res_zero_q  <= res_zero_d;
      res_neg_q   <= res_neg_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.alu_A     = ex_a_q;
  assign bus.alu_B     = ex_b_q;
  assign bus.alu_C     = ex_c_q;
  assign bus.alu_op    = ex_op_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.res_rd    = res_rd_q;
  assign bus.res_zero  = res_zero_q;
  assign bus.res_neg   = res_neg_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage with a behavioural ALU alongside it.
// An in-order architectural model (register array + queue of expected
// results) is checked every cycle; directed sequences pin the model with
// hand-computed literals.
module tb_alu_issue_stage;

  localparam int NREGS = 4;
  localparam int DW    = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_issue_stage_if #(.NREGS(NREGS), .DW(DW)) bus ();

  alu_issue_stage #(.NREGS(NREGS), .DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Behavioural ALU fed by the stage's registered operands.
  logic [15:0] alu_w;
  always_comb begin
    alu_w = '0;
    case (bus.alu_op)
      3'd0:    alu_w = -bus.alu_A;
      3'd1:    alu_w = bus.alu_A + 16'd1;
      3'd2:    alu_w = bus.alu_A + bus.alu_B + {15'd0, bus.alu_C};
      3'd3:    alu_w = bus.alu_A + 16'($signed(bus.alu_B) >>> 1);
      3'd4:    alu_w = bus.alu_A & bus.alu_B;
      3'd5:    alu_w = bus.alu_A | bus.alu_B;
      3'd6:    alu_w = {bus.alu_A[7:0], bus.alu_B[7:0]};
      default: alu_w = '0;
    endcase
  end
  assign bus.alu_W    = alu_w;
  assign bus.alu_zero = (alu_w == 16'd0);
  assign bus.alu_neg  = alu_w[15];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Architectural result of one instruction, from the operation table.
  function automatic logic [15:0] spec_result(input logic [2:0] op, input logic [15:0] a,
                                              input logic [15:0] b, input logic cin,
                                              input logic [15:0] imm);
    int ai, bi;
    ai = int'(a);
    bi = int'($signed(b));
    case (op)
      3'd0:    return 16'(65536 - ai);
      3'd1:    return 16'(ai + 1);
      3'd2:    return 16'(ai + int'(b) + int'(cin));
      3'd3:    return 16'(ai + (bi >>> 1));
      3'd4:    return a & b;
      3'd5:    return a | b;
      3'd6:    return 16'((ai % 256) * 256 + (int'(b) % 256));
      default: return imm;
    endcase
  endfunction

  typedef struct {
    logic [15:0] data;
    logic [1:0]  rd;
  } exp_t;

  typedef struct {
    logic [15:0] data;
    logic        zero;
    logic        neg;
    int          cyc;
  } log_t;

  logic [15:0] m_reg [NREGS];
  exp_t        exp_q [$];
  log_t        got_q [$];
  int          cyc = 0;

  logic        stall_prev = 1'b0;
  logic [15:0] prev_data;
  logic [1:0]  prev_rd;
  logic        prev_zero, prev_neg;

  // Compare process: samples one time unit before each rising edge.
  initial begin
    for (int i = 0; i < NREGS; i++) m_reg[i] = '0;
    forever begin
      @(negedge clk);
      #4;
      cyc++;
      if (rst) begin
        for (int i = 0; i < NREGS; i++) m_reg[i] = '0;
        exp_q.delete();
        stall_prev = 1'b0;
      end else begin
        if (bus.alu_op != 3'd2) chk("alu_C_forced0", 32'(bus.alu_C), 32'd0);
        chk("in_ready", 32'(bus.in_ready), 32'(!(exp_q.size() == 2 && !bus.res_ready)));
        if (exp_q.size() == 0) chk("res_valid_idle", 32'(bus.res_valid), 32'd0);
        if (exp_q.size() == 2) chk("res_valid_full", 32'(bus.res_valid), 32'd1);
        if (stall_prev) begin
          chk("hold_valid", 32'(bus.res_valid), 32'd1);
          chk("hold_data", 32'(bus.res_data), 32'(prev_data));
          chk("hold_rd", 32'(bus.res_rd), 32'(prev_rd));
          chk("hold_flags", {30'd0, bus.res_zero, bus.res_neg}, {30'd0, prev_zero, prev_neg});
        end
        if (bus.res_valid && bus.res_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result: got data %04h with nothing outstanding", bus.res_data);
          end else begin
            exp_t e;
            log_t l;
            e = exp_q.pop_front();
            chk("res_data", 32'(bus.res_data), 32'(e.data));
            chk("res_rd", 32'(bus.res_rd), 32'(e.rd));
            chk("res_zero", 32'(bus.res_zero), 32'(e.data == 16'd0));
            chk("res_neg", 32'(bus.res_neg), 32'(e.data[15]));
          end
          begin
            log_t l;
            l.data = bus.res_data;
            l.zero = bus.res_zero;
            l.neg  = bus.res_neg;
            l.cyc  = cyc;
            got_q.push_back(l);
          end
          $display("result rd=%0d data=%04h zero=%0b neg=%0b cycle=%0d",
                   bus.res_rd, bus.res_data, bus.res_zero, bus.res_neg, cyc);
        end
        if (bus.in_valid && bus.in_ready) begin
          exp_t e;
          e.data = spec_result(bus.in_op, m_reg[bus.in_rs1], m_reg[bus.in_rs2],
                               bus.in_cin, bus.in_imm);
          e.rd   = bus.in_rd;
          m_reg[bus.in_rd] = e.data;
          exp_q.push_back(e);
        end
        stall_prev = bus.res_valid & ~bus.res_ready;
        prev_data  = bus.res_data;
        prev_rd    = bus.res_rd;
        prev_zero  = bus.res_zero;
        prev_neg   = bus.res_neg;
      end
    end
  end

  // Present one instruction from a falling edge and hold it until taken.
  task automatic issue(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                       input logic [1:0] rs2, input logic cin, input logic [15:0] imm);
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_rd    = rd;
    bus.in_rs1   = rs1;
    bus.in_rs2   = rs2;
    bus.in_cin   = cin;
    bus.in_imm   = imm;
    for (int n = 0; n < 60; n++) begin
      #1;
      if (bus.in_ready) begin
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    checks++;
    errors++;
    $display("FAIL issue_timeout: in_ready stayed 0, required 1 within 60 cycles");
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 100 && exp_q.size() != 0; n++) @(negedge clk);
    chk("drain_outstanding", 32'(exp_q.size()), 32'd0);
  endtask

  function automatic log_t got_at(input int idx);
    log_t e;
    e.data = 'x;
    e.zero = 1'bx;
    e.neg  = 1'bx;
    e.cyc  = -1000;
    if (idx >= 0 && idx < got_q.size()) e = got_q[idx];
    return e;
  endfunction

  task automatic expect_res(input string name, input int idx, input logic [15:0] data,
                            input logic zero, input logic neg);
    log_t e;
    e = got_at(idx);
    chk(name, {13'd0, e.zero, e.neg, 1'b0, e.data}, {13'd0, zero, neg, 1'b0, data});
  endtask

  task automatic expect_gap(input string name, input int idx);
    chk(name, 32'(got_at(idx).cyc - got_at(idx - 1).cyc), 32'd1);
  endtask

  int base;

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_op     = '0;
    bus.in_rd     = '0;
    bus.in_rs1    = '0;
    bus.in_rs2    = '0;
    bus.in_cin    = 1'b0;
    bus.in_imm    = '0;
    bus.res_ready = 1'b1;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_res_valid", 32'(bus.res_valid), 32'd0);
    chk("reset_in_ready", 32'(bus.in_ready), 32'd1);
    chk("reset_res_data", 32'(bus.res_data), 32'd0);
    chk("reset_res_rd_flags", {29'd0, bus.res_rd, bus.res_zero}, 32'd0);
    chk("reset_alu_ops", {bus.alu_A, bus.alu_B}, 32'd0);
    chk("reset_alu_op_c", {28'd0, bus.alu_op, bus.alu_C}, 32'd0);

    // LOADI r1=5, LOADI r2=3, ADD r3=r1+r2+1 back-to-back
    base = got_q.size();
    issue(3'd7, 2'd1, 2'd0, 2'd0, 1'b0, 16'd5);
    issue(3'd7, 2'd2, 2'd0, 2'd0, 1'b0, 16'd3);
    issue(3'd2, 2'd3, 2'd1, 2'd2, 1'b1, 16'd0);
    drain();
    chk("ldadd_count", 32'(got_q.size() - base), 32'd3);
    expect_res("ldi_r1", base, 16'h0005, 1'b0, 1'b0);
    expect_res("ldi_r2", base + 1, 16'h0003, 1'b0, 1'b0);
    expect_res("add_r3", base + 2, 16'h0009, 1'b0, 1'b0);
    expect_gap("b2b_gap1", base + 1);
    expect_gap("b2b_gap2", base + 2);
    base = got_q.size();
    issue(3'd5, 2'd0, 2'd3, 2'd3, 1'b0, 16'd0);
    drain();
    expect_res("read_r3", base, 16'h0009, 1'b0, 1'b0);

    // NEG of 1 then INC back to zero
    base = got_q.size();
    issue(3'd7, 2'd1, 2'd0, 2'd0, 1'b0, 16'd1);
    issue(3'd0, 2'd0, 2'd1, 2'd0, 1'b0, 16'd0);
    issue(3'd1, 2'd0, 2'd0, 2'd0, 1'b1, 16'd0);
    drain();
    expect_res("neg_r0", base + 1, 16'hFFFF, 1'b0, 1'b1);
    expect_res("inc_r0", base + 2, 16'h0000, 1'b1, 1'b0);

    // A + (B >>> 1) with negative B, and byte concatenation
    base = got_q.size();
    issue(3'd7, 2'd1, 2'd0, 2'd0, 1'b0, 16'h0010);
    issue(3'd7, 2'd2, 2'd0, 2'd0, 1'b0, 16'hFFF0);
    issue(3'd3, 2'd3, 2'd1, 2'd2, 1'b0, 16'd0);
    issue(3'd7, 2'd1, 2'd0, 2'd0, 1'b0, 16'h12AB);
    issue(3'd7, 2'd2, 2'd0, 2'd0, 1'b0, 16'h34CD);
    issue(3'd6, 2'd3, 2'd1, 2'd2, 1'b0, 16'd0);
    drain();
    expect_res("asr_add", base + 2, 16'h0008, 1'b0, 1'b0);
    expect_res("cat", base + 5, 16'hABCD, 1'b0, 1'b1);

    // Backpressure: hold the result for several cycles with 3 queued
    base = got_q.size();
    bus.res_ready = 1'b0;
    fork
      begin
        issue(3'd7, 2'd1, 2'd0, 2'd0, 1'b0, 16'h0007);
        issue(3'd7, 2'd2, 2'd0, 2'd0, 1'b0, 16'h0008);
        issue(3'd5, 2'd3, 2'd1, 2'd2, 1'b0, 16'd0);
      end
      begin
        repeat (4) @(negedge clk);
        #2;
        chk("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
        chk("bp_res_held", {15'd0, bus.res_valid, bus.res_data}, {15'd0, 1'b1, 16'h0007});
        @(negedge clk);
        bus.res_ready = 1'b1;
      end
    join
    drain();
    chk("bp_count", 32'(got_q.size() - base), 32'd3);
    expect_res("bp_first", base, 16'h0007, 1'b0, 1'b0);
    expect_res("bp_second", base + 1, 16'h0008, 1'b0, 1'b0);
    expect_res("bp_third", base + 2, 16'h000F, 1'b0, 1'b0);

    // INC chain through the wrap point with no gaps
    issue(3'd7, 2'd1, 2'd0, 2'd0, 1'b0, 16'hFFFE);
    base = got_q.size();
    for (int i = 0; i < 4; i++) issue(3'd1, 2'd1, 2'd1, 2'd0, 1'b0, 16'd0);
    drain();
    chk("inc_count", 32'(got_q.size() - base), 32'd5);
    expect_res("inc_ffff", base + 1, 16'hFFFF, 1'b0, 1'b1);
    expect_res("inc_0000", base + 2, 16'h0000, 1'b1, 1'b0);
    expect_res("inc_0001", base + 3, 16'h0001, 1'b0, 1'b0);
    expect_res("inc_0002", base + 4, 16'h0002, 1'b0, 1'b0);
    for (int i = 2; i <= 4; i++) expect_gap("inc_gap", base + i);

    // Reset with both EX and RES occupied
    bus.res_ready = 1'b0;
    issue(3'd7, 2'd2, 2'd0, 2'd0, 1'b0, 16'h1234);
    issue(3'd7, 2'd3, 2'd0, 2'd0, 1'b0, 16'h5678);
    base = got_q.size();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_mid_res_valid", 32'(bus.res_valid), 32'd0);
    chk("rst_mid_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_mid_res_data", 32'(bus.res_data), 32'd0);
    bus.res_ready = 1'b1;
    for (int i = 0; i < 4; i++) issue(3'd5, 2'(i), 2'(i), 2'(i), 1'b0, 16'd0);
    drain();
    chk("rst_read_count", 32'(got_q.size() - base), 32'd4);
    for (int i = 0; i < 4; i++) expect_res("rst_reg_zero", base + i, 16'h0000, 1'b1, 1'b0);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at 200000, required completion earlier");
    $fatal(1, "watchdog");
  end

endmodule
